press_driver: RTL

//  Transmit side of the button-press interface. Converts one-cycle press

---
 rtl/press_driver.sv | 129 ++++++++++++
 1 files changed

// File: rtl/press_driver.sv
// Button-press transmitter: turns one-cycle press requests (external or LFSR
// "cyber player") into a held button level followed by a guaranteed low gap.
module press_driver #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic       auto_en,
  input  logic       strobe,
  input  logic [9:0] threshold,
  output logic       press,
  output logic       released,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned LFSR_W  = 10;
  localparam int unsigned PEND_W  = $clog2(MAX_PENDING + 1);
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PEND_W-1:0]   r_pending;
  logic [LFSR_W-1:0]   r_lfsr;
  logic                r_press;
  logic                r_released;
  logic                r_overflow;

  logic                w_auto_req;
  logic                w_req;
  logic                w_deq;
  logic                w_full;

  // fire and an auto request in the same cycle merge into a single request
  assign w_auto_req = auto_en & strobe & (r_lfsr < threshold);
  assign w_req      = fire | w_auto_req;
  assign w_deq      = (r_state == S_IDLE) && (r_pending != '0);
  assign w_full     = (r_pending == PEND_W'(MAX_PENDING));

  // Fibonacci LFSR x^10 + x^7 + 1; the all-zero state is unreachable from 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_W'(1);
    end else if (auto_en) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[9] ^ r_lfsr[6]};
    end
  end

  // Saturating request queue; a dequeue cancels a same-cycle request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_req && w_deq) begin
        r_pending <= r_pending;
      end else if (w_req) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_pending <= r_pending + PEND_W'(1);
        end
      end else if (w_deq) begin
        r_pending <= r_pending - PEND_W'(1);
      end
    end
  end

  // Hold / gap sequencer with registered Moore outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_press    <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_released <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pending != '0) begin
            r_state <= S_PRESS;
            r_cnt   <= '0;
            r_press <= 1'b1;
          end
        end
        S_PRESS: begin
          if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            r_state    <= S_GAP;
            r_cnt      <= '0;
            r_press    <= 1'b0;
            r_released <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_press <= 1'b0;
        end
      endcase
    end
  end

  assign press    = r_press;
  assign released = r_released;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) || (r_pending != '0);

endmodule
